// File: rtl/fir_mac_filter.sv
// Time-multiplexed FIR filter: one multiply-accumulate per clock over TAPS
// runtime-loadable coefficients, with round-half-up, output saturation,
// delay-line flush and a valid/ready input handshake.
module fir_mac_filter #(
    parameter int WIDTH      = 20,
    parameter int TAPS       = 8,
    parameter int COEF_WIDTH = 16,
    parameter int COEF_FRAC  = 14
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic signed [WIDTH-1:0]      in_sample,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         flush,
    input  logic                         coef_we,
    input  logic [$clog2(TAPS)-1:0]      coef_addr,
    input  logic signed [COEF_WIDTH-1:0] coef_data,
    output logic signed [WIDTH-1:0]      out_sample,
    output logic                         out_valid,
    output logic                         sat,
    output logic                         busy
);

    localparam int PTR_W  = $clog2(TAPS);
    localparam int PROD_W = WIDTH + COEF_WIDTH;
    localparam int ACC_W  = PROD_W + PTR_W;

    localparam logic [PTR_W-1:0] LAST_TAP = (PTR_W)'(TAPS - 1);
    localparam logic [PTR_W:0]   TAPS_W   = (PTR_W + 1)'(TAPS);

    localparam logic signed [COEF_WIDTH-1:0] COEF_ONE =
        {{(COEF_WIDTH-1){1'b0}}, 1'b1} << COEF_FRAC;
    localparam logic signed [ACC_W-1:0] RND_HALF =
        {{(ACC_W-1){1'b0}}, 1'b1} << (COEF_FRAC - 1);
    localparam logic signed [ACC_W-1:0] OUT_MAX =
        {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN =
        {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_ROUND
    } state_t;

    state_t r_state;
    state_t w_next;

    logic signed [WIDTH-1:0]      r_dline [TAPS];
    logic signed [COEF_WIDTH-1:0] r_coef  [TAPS];
    logic [PTR_W-1:0]             r_wptr;
    logic [PTR_W-1:0]             r_tap;
    logic signed [ACC_W-1:0]      r_acc;

    logic [PTR_W-1:0]             w_rd_idx;
    logic                         w_last_tap;
    logic                         w_addr_ok;
    logic signed [PROD_W-1:0]     w_coef_x;
    logic signed [PROD_W-1:0]     w_samp_x;
    logic signed [PROD_W-1:0]     w_prod;
    logic signed [ACC_W-1:0]      w_acc_rnd;
    logic signed [ACC_W-1:0]      w_rnd;
    logic                         w_ovf_hi;
    logic                         w_ovf_lo;
    logic signed [WIDTH-1:0]      w_clip;

    assign w_last_tap = (r_tap == LAST_TAP);

    // With a power-of-two TAPS every address is in range; otherwise reject the top codes.
    generate
        if (TAPS == (1 << PTR_W)) begin : g_addr_full
            assign w_addr_ok = 1'b1;
        end else begin : g_addr_part
            assign w_addr_ok = ({1'b0, coef_addr} < TAPS_W);
        end
    endgenerate

    // Circular read index x[n-k]: write pointer minus tap, wrapped modulo TAPS.
    always_comb begin
        if (r_tap <= r_wptr) begin
            w_rd_idx = r_wptr - r_tap;
        end else begin
            w_rd_idx = r_wptr + (PTR_W)'(TAPS) - r_tap;
        end
    end

    // Full-width signed product; operands sign-extended so the low PROD_W bits are exact.
    always_comb begin
        w_coef_x = {{WIDTH{r_coef[r_tap][COEF_WIDTH-1]}}, r_coef[r_tap]};
        w_samp_x = {{COEF_WIDTH{r_dline[w_rd_idx][WIDTH-1]}}, r_dline[w_rd_idx]};
        w_prod   = w_coef_x * w_samp_x;
    end

    // Round half toward +inf, then clip to the signed output range.
    always_comb begin
        w_acc_rnd = r_acc + RND_HALF;
        w_rnd     = w_acc_rnd >>> COEF_FRAC;
        w_ovf_hi  = (w_rnd > OUT_MAX);
        w_ovf_lo  = (w_rnd < OUT_MIN);
        if (w_ovf_hi) begin
            w_clip = OUT_MAX[WIDTH-1:0];
        end else if (w_ovf_lo) begin
            w_clip = OUT_MIN[WIDTH-1:0];
        end else begin
            w_clip = w_rnd[WIDTH-1:0];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        w_next   = r_state;
        busy     = 1'b0;
        in_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next = S_MAC;
                end
            end
            S_MAC: begin
                busy = 1'b1;
                if (w_last_tap) begin
                    w_next = S_ROUND;
                end
            end
            S_ROUND: begin
                busy   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: coefficient/delay-line updates, MAC accumulation, output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < TAPS; i++) begin
                r_dline[i] <= '0;
                r_coef[i]  <= '0;
            end
            r_coef[0]  <= COEF_ONE;
            r_wptr     <= '0;
            r_tap      <= '0;
            r_acc      <= '0;
            out_sample <= '0;
            out_valid  <= 1'b0;
            sat        <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            sat       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Coefficients are only read in MAC, so a write alongside an accept is seen by that sample.
                    if (coef_we && w_addr_ok) begin
                        r_coef[coef_addr] <= coef_data;
                    end
                    if (in_valid) begin
                        r_dline[r_wptr] <= in_sample;
                        r_acc           <= '0;
                        r_tap           <= '0;
                    end else if (flush) begin
                        for (int unsigned i = 0; i < TAPS; i++) begin
                            r_dline[i] <= '0;
                        end
                    end
                end
                S_MAC: begin
                    r_acc <= r_acc + {{PTR_W{w_prod[PROD_W-1]}}, w_prod};
                    if (!w_last_tap) begin
                        r_tap <= r_tap + 1'b1;
                    end
                end
                S_ROUND: begin
                    out_sample <= w_clip;
                    out_valid  <= 1'b1;
                    sat        <= w_ovf_hi | w_ovf_lo;
                    if (r_wptr == LAST_TAP) begin
                        r_wptr <= '0;
                    end else begin
                        r_wptr <= r_wptr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
